// File: rtl/io_bus_master_if.sv
// rtl/io_bus_master_if.sv - request/response handshake and dma_io bus bundle for io_bus_master
interface io_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [13:0] req_adr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [13:0] dma_io_radr;
  logic        dma_io_radr_en;
  logic [31:0] dma_io_rdata;

  modport master (
    input  req_valid, req_op, req_adr, req_wdata, rsp_ready, dma_io_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en
  );

  modport slave (
    output req_valid, req_op, req_adr, req_wdata, rsp_ready, dma_io_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en
  );
endinterface

// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - single-command IO bus initiator with READ/WRITE and atomic SET/CLR
module io_bus_master #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  io_bus_master_if.master io_bus
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RSP} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [13:0] adr_q;
  logic [31:0] mask_q;
  logic [31:0] old_q;
  logic [2:0]  cnt_q;

  logic        we_q;
  logic [13:0] wadr_q;
  logic [31:0] wdata_q;
  logic        radr_en_q;
  logic [13:0] radr_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;

  logic [31:0] rmw_wdata_d;

  // Merge is taken straight from the bus so the write can be issued on the edge after sampling.
  always_comb begin
    rmw_wdata_d = io_bus.dma_io_rdata;
    case (op_q)
      OP_SET:  rmw_wdata_d = io_bus.dma_io_rdata | mask_q;
      OP_CLR:  rmw_wdata_d = io_bus.dma_io_rdata & ~mask_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      adr_q       <= 14'd0;
      mask_q      <= 32'd0;
      old_q       <= 32'd0;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      wadr_q      <= 14'd0;
      wdata_q     <= 32'd0;
      radr_en_q   <= 1'b0;
      radr_q      <= 14'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      // Strobes and their address/data are single-cycle pulses; zero unless set below.
      we_q      <= 1'b0;
      wadr_q    <= 14'd0;
      wdata_q   <= 32'd0;
      radr_en_q <= 1'b0;
      radr_q    <= 14'd0;
      case (state_q)
        IDLE: begin
          if (io_bus.req_valid) begin
            op_q   <= io_bus.req_op;
            adr_q  <= io_bus.req_adr;
            mask_q <= io_bus.req_wdata;
            if (io_bus.req_op == OP_WRITE) begin
              state_q <= WR;
              we_q    <= 1'b1;
              wadr_q  <= io_bus.req_adr;
              wdata_q <= io_bus.req_wdata;
            end else begin
              state_q   <= RD;
              radr_en_q <= 1'b1;
              radr_q    <= io_bus.req_adr;
            end
          end
        end
        RD: begin
          state_q <= WAIT;
          cnt_q   <= 3'(RD_LAT);
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            old_q <= io_bus.dma_io_rdata;
            if (op_q == OP_READ) begin
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= io_bus.dma_io_rdata;
            end else begin
              state_q <= WR;
              we_q    <= 1'b1;
              wadr_q  <= adr_q;
              wdata_q <= rmw_wdata_d;
            end
          end
        end
        WR: begin
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= (op_q == OP_WRITE) ? 32'd0 : old_q;
        end
        RSP: begin
          if (io_bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_bus.req_ready      = (state_q == IDLE);
  assign io_bus.rsp_valid      = rsp_valid_q;
  assign io_bus.rsp_rdata      = rsp_rdata_q;
  assign io_bus.dma_io_we      = we_q;
  assign io_bus.dma_io_wadr    = wadr_q;
  assign io_bus.dma_io_wdata   = wdata_q;
  assign io_bus.dma_io_radr_en = radr_en_q;
  assign io_bus.dma_io_radr    = radr_q;
endmodule
